// File: rtl/bus_pkg.sv
`default_nettype none
// ==== bus_pkg: shared bus constants and split-port state encoding -- Rev 1.0 ====
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_SPLIT    = 3'd2,
    ST_ACK_WAIT = 3'd3,
    ST_RESP     = 3'd4
  } port_state_e;

  localparam int unsigned DEF_ACK_TIMEOUT = 64;
  localparam int unsigned DEF_HOLDOFF     = 2;
  localparam int unsigned DEF_MIN_SPLIT   = 2;
  localparam int unsigned PORT_TIMER_W    = 8;

  localparam int unsigned BUS_NUM_MASTERS = 4;
  localparam int unsigned BUS_NUM_SLAVES  = 8;

endpackage
`default_nettype wire

// File: rtl/split_timer.sv
`default_nettype none
// ==== split_timer: loadable saturating down-counter with zero flag -- Rev 1.0 ====
module split_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; decrement stops at zero instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/slave_split_port.sv
`default_nettype none
// ==== slave_split_port: bus slave port sequencing short and split accesses -- Rev 1.0 ====
module slave_split_port
  import bus_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int unsigned HOLDOFF     = DEF_HOLDOFF,
  parameter int unsigned MIN_SPLIT   = DEF_MIN_SPLIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic       req_long,
  output logic       req_ready,
  output logic       core_start,
  input  logic       core_done,
  output logic       split,
  input  logic       split_ack,
  output logic       resp_valid,
  output logic       ack_err,
  output logic [2:0] state
);

  localparam int unsigned TW = PORT_TIMER_W;

  port_state_e r_state;
  logic        r_split;
  logic        r_core_start;
  logic        r_resp_valid;
  logic        r_ack_err;
  logic        r_done_seen;

  logic          w_hold_zero;
  logic          w_phase_zero;
  logic          w_accept;
  logic          w_split_leave;
  logic          w_ack_timeout;
  logic          w_to_idle;
  logic          w_phase_load;
  logic [TW-1:0] w_phase_value;

  assign req_ready     = (r_state == ST_IDLE) && w_hold_zero;
  assign w_accept      = req_ready && req_valid;
  // A done arriving in the current cycle counts just like a latched one.
  assign w_split_leave = (r_state == ST_SPLIT) && (r_done_seen || core_done) && w_phase_zero;
  assign w_ack_timeout = (r_state == ST_ACK_WAIT) && !split_ack && w_phase_zero;
  assign w_to_idle     = (r_state == ST_RESP) || w_ack_timeout;

  // The phase timer counts MIN_SPLIT in SPLIT, then ACK_TIMEOUT in ACK_WAIT.
  assign w_phase_load  = (w_accept && req_long) || w_split_leave;
  assign w_phase_value = w_split_leave ? TW'(ACK_TIMEOUT - 1) : TW'(MIN_SPLIT - 1);

  split_timer #(.WIDTH(TW)) u_hold_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load       (w_to_idle),
    .load_value (TW'(HOLDOFF)),
    .dec        (1'b1),
    .zero       (w_hold_zero)
  );

  split_timer #(.WIDTH(TW)) u_phase_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load       (w_phase_load),
    .load_value (w_phase_value),
    .dec        (1'b1),
    .zero       (w_phase_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_split      <= 1'b0;
      r_core_start <= 1'b0;
      r_resp_valid <= 1'b0;
      r_ack_err    <= 1'b0;
      r_done_seen  <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_resp_valid <= 1'b0;
      r_ack_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_core_start <= 1'b1;
            r_done_seen  <= 1'b0;
            if (req_long) begin
              r_state <= ST_SPLIT;
              r_split <= 1'b1;
            end else begin
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (core_done) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        ST_SPLIT: begin
          if (w_split_leave) begin
            r_state     <= ST_ACK_WAIT;
            r_split     <= 1'b0;
            r_done_seen <= 1'b0;
          end else if (core_done) begin
            r_done_seen <= 1'b1;
          end
        end
        ST_ACK_WAIT: begin
          if (split_ack) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end else if (w_ack_timeout) begin
            r_state   <= ST_IDLE;
            r_ack_err <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_split     <= 1'b0;
          r_done_seen <= 1'b0;
        end
      endcase
    end
  end

  assign split      = r_split;
  assign core_start = r_core_start;
  assign resp_valid = r_resp_valid;
  assign ack_err    = r_ack_err;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_slave_split_port.sv
`default_nettype none
// ==== tb_slave_split_port: directed vector bench for slave_split_port -- Rev 1.0 ====
module tb_slave_split_port;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_SPLT = 3'd2;
  localparam logic [2:0] S_ACKW = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic       clk;
  logic       rstn;
  logic       req_valid;
  logic       req_long;
  logic       req_ready;
  logic       core_start;
  logic       core_done;
  logic       split;
  logic       split_ack;
  logic       resp_valid;
  logic       ack_err;
  logic [2:0] state;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       v;
    logic       l;
    logic       d;
    logic       a;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[15];

  slave_split_port #(
    .ACK_TIMEOUT (8),
    .HOLDOFF     (2),
    .MIN_SPLIT   (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_long   (req_long),
    .req_ready  (req_ready),
    .core_start (core_start),
    .core_done  (core_done),
    .split      (split),
    .split_ack  (split_ack),
    .resp_valid (resp_valid),
    .ack_err    (ack_err),
    .state      (state)
  );

  assign outs = {req_ready, split, core_start, resp_valid, ack_err, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ex(input logic rdy, input logic sp, input logic cs,
                                    input logic rv, input logic er, input logic [2:0] st);
    return {rdy, sp, cs, rv, er, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic d, input logic a);
    req_valid = v;
    req_long  = l;
    core_done = d;
    split_ack = a;
  endtask

  task automatic check_out(input string name, input logic [7:0] exp);
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy/split/cs/resp/err/state=%b, expected %b", name, outs, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Counts cycles split is seen high, starting from the already-observed first cycle.
  task automatic measure_split(input int done_at, output int cnt);
    cnt = 1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      drive(1'b0, 1'b0, (cyc == done_at), 1'b0);
      tick();
      if (!split) break;
      cnt++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int wait_err;
    int saw;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 0, S_IDLE)};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, 1, 0, 0, S_EXEC)};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, S_EXEC)};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, S_EXEC)};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, S_EXEC)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 1, 0, S_RESP)};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, S_IDLE)};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, S_IDLE)};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, S_IDLE)};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, S_IDLE)};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, 1, 0, 0, S_EXEC)};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 1, 0, S_RESP)};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, S_IDLE)};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, S_IDLE)};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, S_IDLE)};

    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_out("reset state", ex(1, 0, 0, 0, 0, S_IDLE));
    #2 rstn = 1'b1;
    tick();
    check_out("idle after release", ex(1, 0, 0, 0, 0, S_IDLE));

    // Short accesses, spurious acks, holdoff and done-with-start.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].a);
      tick();
      check_out($sformatf("vector %0d", i), vecs[i].exp);
    end

    // Long split access with late core_done and ack 4 cycles after the fall.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("split accept", ex(0, 1, 1, 0, 0, S_SPLT));
    measure_split(11, cnt);
    check_int("split high cycles long", cnt, 11);
    check_out("split fall ack_wait", ex(0, 0, 0, 0, 0, S_ACKW));
    repeat (4) tick();
    check_out("ack_wait holds", ex(0, 0, 0, 0, 0, S_ACKW));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("resp after ack", ex(0, 0, 0, 1, 0, S_RESP));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("idle after resp", ex(0, 0, 0, 0, 0, S_IDLE));
    repeat (2) tick();
    check_out("ready after holdoff", ex(1, 0, 0, 0, 0, S_IDLE));

    // Early done then ack timeout.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("early split accept", ex(0, 1, 1, 0, 0, S_SPLT));
    measure_split(1, cnt);
    check_int("split high cycles early done", cnt, 2);
    wait_err = 0;
    saw = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (resp_valid) saw = 1;
      if (ack_err) begin
        wait_err = n;
        break;
      end
    end
    check_int("ack_err delay", wait_err, 8);
    check_int("no resp on timeout", saw, 0);
    check_out("timeout state", ex(0, 0, 0, 0, 1, S_IDLE));
    tick();
    check_out("ack_err one cycle", ex(0, 0, 0, 0, 0, S_IDLE));
    tick();
    check_out("ready after timeout holdoff", ex(1, 0, 0, 0, 0, S_IDLE));

    // Ack arriving in the expiry cycle beats the timeout.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    measure_split(1, cnt);
    repeat (7) tick();
    check_out("ack_wait at expiry", ex(0, 0, 0, 0, 0, S_ACKW));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("ack wins over timeout", ex(0, 0, 0, 1, 0, S_RESP));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check_out("ready after ack race", ex(1, 0, 0, 0, 0, S_IDLE));

    // Asynchronous reset in the middle of SPLIT.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("split before reset", ex(0, 1, 0, 0, 0, S_SPLT));
    #2 rstn = 1'b0;
    #1;
    check_out("async reset mid split", ex(1, 0, 0, 0, 0, S_IDLE));
    #2 rstn = 1'b1;
    tick();
    check_out("ready after reset release", ex(1, 0, 0, 0, 0, S_IDLE));

    // Reset in ACK_WAIT abandons the transaction silently.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    measure_split(1, cnt);
    check_out("ack_wait before reset", ex(0, 0, 0, 0, 0, S_ACKW));
    #2 rstn = 1'b0;
    #3 rstn = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    saw = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (resp_valid || ack_err) saw = 1;
    end
    check_int("no resp or err after abandon", saw, 0);
    check_out("idle after abandon", ex(1, 0, 0, 0, 0, S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slave_split_port.md
SLAVE_SPLIT_PORT -- requirements
Module: slave_split_port

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, 64, cycles to wait for split_ack before aborting (1..255).
REQ-002 SHALL have parameter HOLDOFF, 2, cycles after a transaction ends during which req_ready stays low (0..15).
REQ-003 SHALL have parameter MIN_SPLIT, 2, minimum cycles split stays high once raised (1..15).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have req_valid  input  1  master has addressed this slave (sampled only when req_ready=1).
REQ-006 SHALL have req_long  input  1  qualifies req_valid: access needs a split.
REQ-007 SHALL have req_ready  output  1  port can accept a new access.
REQ-008 SHALL have core_start  output  1  one-cycle pulse starting the slave core.
REQ-009 SHALL have core_done  input  1  slave core finished (may be a pulse).
REQ-010 SHALL have split  output  1  to bus controller slave line: high = split in progress, falling edge = done.
REQ-011 SHALL have split_ack  input  1  one-cycle ack from bus controller: original master regranted.
REQ-012 SHALL have resp_valid  output  1  one-cycle pulse telling the bus responder to return data.
REQ-013 SHALL have ack_err  output  1  one-cycle pulse on ACK_TIMEOUT expiry.
REQ-014 SHALL have state  output  3  current FSM state, for debug.

Function
REQ-015 States SHALL be IDLE, EXEC, SPLIT, ACK_WAIT, RESP; all outputs registered.
REQ-016 req_ready SHALL equal (state==IDLE and holdoff counter==0).
REQ-017 IDLE with accepted req_valid and req_long=0 SHALL go to EXEC and pulse core_start the next cycle.
REQ-018 IDLE with accepted req_valid and req_long=1 SHALL go to SPLIT, raising split and pulsing core_start the next cycle.
REQ-019 EXEC SHALL wait for core_done, then go to RESP; split stays low throughout.
REQ-020 SPLIT SHALL latch core_done and leave only when latched done and split has been high for at least MIN_SPLIT cycles; split drops on entry to ACK_WAIT.
REQ-021 ACK_WAIT SHALL go to RESP on split_ack; otherwise after ACK_TIMEOUT cycles without ack it SHALL pulse ack_err and go to IDLE.
REQ-022 split_ack and ack and core_done SHALL be ignored in all states where not listed above; split_ack arriving in the same cycle as timeout expiry SHALL win (go to RESP, no ack_err).
REQ-023 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE.
REQ-024 On every entry to IDLE from RESP or ACK_WAIT the holdoff counter SHALL load HOLDOFF and decrement to 0, so split cannot re-rise before the controller frees the slave.
REQ-025 Counters SHALL saturate, never wrap; core_done in the same cycle as core_start SHALL be honoured.

Reset
REQ-026 rstn low SHALL immediately force state=IDLE, split=0, core_start=0, resp_valid=0, ack_err=0, all counters and latches 0, so req_ready=1 after reset.
REQ-027 Reset mid-SPLIT or mid-ACK_WAIT SHALL abandon the transaction with no resp_valid or ack_err.

Structure
REQ-028 State encoding and parameter defaults SHALL live in shared package bus_pkg alongside bus-controller constants.
REQ-029 One sub-module, split_timer (loadable saturating down-counter with zero flag), SHALL be instantiated for the timeout and holdoff counts.

Verification
REQ-030 Short access: req_valid, req_long=0, core_done 3 cycles after core_start -> split never high, resp_valid 1 cycle after core_done, req_ready low 2 cycles after.
REQ-031 Split access: req_long=1, core_done after 10 cycles, split_ack 4 cycles after split falls -> split high 11 cycles, resp_valid 1 cycle after ack.
REQ-032 Early done: core_done same cycle as core_start, MIN_SPLIT=2 -> split high exactly 2 cycles.
REQ-033 Timeout: ACK_TIMEOUT=8, no split_ack -> ack_err pulse 8 cycles after split falls, no resp_valid, IDLE.
REQ-034 Spurious split_ack in IDLE and EXEC -> no state change; req_valid during holdoff -> not accepted.
REQ-035 rstn pulsed low mid-SPLIT -> split=0 asynchronously, state=IDLE, req_ready=1 on first clock after release.
